// File: rtl/step_countdown_controller_if.sv
// Purpose: bundles the countdown / breakpoint control and status signals that
//          pass between clock_control and step_countdown_controller.
// Ports (via modports):
//   master : drives core_clock, countdown_* controls, breakpoint_*, pc;
//            observes countdown_timed_up, hard_breakpoint, countdown_remaining,
//            countdown_state
//   slave  : the controller side (inverse directions)
interface step_countdown_controller_if #(
  parameter int unsigned COUNT_WIDTH = 24,
  parameter int unsigned PC_WIDTH    = 32
);
  logic                   core_clock;
  logic                   countdown_reset;
  logic                   countdown_load;
  logic [COUNT_WIDTH-1:0] countdown_value;
  logic                   countdown_repeat;
  logic                   breakpoint_enable;
  logic [PC_WIDTH-1:0]    breakpoint_address;
  logic [PC_WIDTH-1:0]    pc;
  logic                   countdown_timed_up;
  logic                   hard_breakpoint;
  logic [COUNT_WIDTH-1:0] countdown_remaining;
  logic [1:0]             countdown_state;

  modport master (
    output core_clock, countdown_reset, countdown_load, countdown_value,
           countdown_repeat, breakpoint_enable, breakpoint_address, pc,
    input  countdown_timed_up, hard_breakpoint, countdown_remaining,
           countdown_state
  );

  modport slave (
    input  core_clock, countdown_reset, countdown_load, countdown_value,
           countdown_repeat, breakpoint_enable, breakpoint_address, pc,
    output countdown_timed_up, hard_breakpoint, countdown_remaining,
           countdown_state
  );
endinterface

// File: rtl/step_countdown_controller.sv
// Purpose: generates the automatic-run stop pulses for clock_control: a
//          programmable core-cycle countdown (countdown_timed_up) and a
//          PC-match hardware breakpoint (hard_breakpoint).
// Ports:
//   clock_100mhz : system clock, all logic on rising edge
//   reset_n      : asynchronous active-low reset
//   bus          : slave side of step_countdown_controller_if
//                  (core_clock, countdown controls, breakpoint compare inputs,
//                   registered pulses, remaining count and state)
module step_countdown_controller #(
  parameter int unsigned COUNT_WIDTH = 24,
  parameter int unsigned PC_WIDTH    = 32
) (
  input  logic                         clock_100mhz,
  input  logic                         reset_n,
  step_countdown_controller_if.slave   bus
);

  localparam int unsigned STATE_WIDTH = 2;

  typedef enum logic [STATE_WIDTH-1:0] {
    IDLE     = 2'b00,
    ARMED    = 2'b01,
    COUNTING = 2'b10
  } state_e;

  state_e                 state_q;
  logic [COUNT_WIDTH-1:0] reload_q;
  logic [COUNT_WIDTH-1:0] counter_q;
  logic                   core_clock_q;
  logic                   match_q;
  logic                   timed_up_q;
  logic                   hard_bp_q;

  logic core_edge;
  logic match;

  // core_clock lives in this clock domain; detect its rising edge
  assign core_edge = bus.core_clock & ~core_clock_q;
  assign match     = bus.breakpoint_enable & (bus.pc == bus.breakpoint_address);

  // Countdown sequencer, breakpoint edge detector and registered outputs
  always_ff @(posedge clock_100mhz or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      reload_q     <= '0;
      counter_q    <= '0;
      core_clock_q <= 1'b0;
      match_q      <= 1'b0;
      timed_up_q   <= 1'b0;
      hard_bp_q    <= 1'b0;
    end else begin
      core_clock_q <= bus.core_clock;
      match_q      <= match;
      timed_up_q   <= 1'b0;
      // Only a fresh arrival at the breakpoint PC in auto mode fires
      hard_bp_q    <= match & ~match_q & ~bus.countdown_reset;

      if (bus.countdown_load) begin
        // Load wins over everything, including a coincident core edge
        reload_q  <= bus.countdown_value;
        counter_q <= bus.countdown_value;
        state_q   <= (bus.countdown_value == '0) ? IDLE : ARMED;
      end else begin
        case (state_q)
          IDLE: begin
          end
          ARMED: begin
            // Keeps the counter at the reload value, which also re-arms
            // after a repeating expiry left it at zero
            counter_q <= reload_q;
            if (!bus.countdown_reset) begin
              state_q <= COUNTING;
            end
          end
          COUNTING: begin
            if (bus.countdown_reset) begin
              counter_q <= reload_q;
              state_q   <= ARMED;
            end else if (core_edge && (counter_q != '0)) begin
              if (counter_q == COUNT_WIDTH'(1)) begin
                counter_q  <= '0;
                timed_up_q <= 1'b1;
                state_q    <= bus.countdown_repeat ? ARMED : IDLE;
              end else begin
                counter_q <= counter_q - COUNT_WIDTH'(1);
              end
            end
          end
          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  assign bus.countdown_timed_up  = timed_up_q;
  assign bus.hard_breakpoint     = hard_bp_q;
  assign bus.countdown_remaining = counter_q;
  assign bus.countdown_state     = state_q;

endmodule
